// File: rtl/dvd_pkg.sv
// Purpose: shared screen geometry, FSM state type and palette helper for the bouncing-logo sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dvd_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPRITE_W = 128;
  localparam int SPRITE_H = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC_X,
    CALC_Y,
    COMMIT
  } bounce_state_t;

  // Palette index runs 1..7; index 0 is reserved and never produced.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/dvd_axis_step.sv
// Purpose: one-axis position step with clamp-and-reflect at 0 and max.
// Latency: combinational.
// Backpressure: none.
module dvd_axis_step (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [2:0] speed,
  input  logic [9:0] max,
  output logic [9:0] next,
  output logic       hit
);

  logic signed [10:0] sum;

  // Signed 11-bit step so a move below 0 is seen as negative instead of wrapping.
  always_comb begin
    sum  = '0;
    next = pos;
    hit  = 1'b0;
    if (dir) begin
      sum = $signed({1'b0, pos}) + $signed({8'd0, speed});
    end else begin
      sum = $signed({1'b0, pos}) - $signed({8'd0, speed});
    end
    if (dir && (sum >= $signed({1'b0, max}))) begin
      next = max;
      hit  = 1'b1;
    end else if (!dir && (sum <= 11'sd0)) begin
      next = '0;
      hit  = 1'b1;
    end else begin
      next = sum[9:0];
    end
  end

endmodule

// File: rtl/dvd_bounce_controller.sv
// Purpose: per-frame sprite motion FSM; steps x then y, then commits position, direction, colour and pulses.
// Latency: outputs update on the 3rd clk edge after the frame_start edge; busy high for 3 cycles.
// Backpressure: none; frame_start while busy, paused or at speed 0 is dropped, never queued.
module dvd_bounce_controller
  import dvd_pkg::*;
#(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int SPRITE_W_P = SPRITE_W,
  parameter int SPRITE_H_P = SPRITE_H,
  parameter int INIT_X     = 200,
  parameter int INIT_Y     = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pause,
  input  logic [2:0] speed,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] color_idx,
  output logic       bounce,
  output logic       corner,
  output logic       busy
);

  localparam logic [9:0] X_MAX  = 10'(H_ACTIVE_P - SPRITE_W_P);
  localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE_P - SPRITE_H_P);
  localparam logic [9:0] X_INIT = 10'(INIT_X);
  localparam logic [9:0] Y_INIT = 10'(INIT_Y);

  bounce_state_t state, next_state;

  logic [2:0] speed_q;
  logic [9:0] nx, ny;
  logic       hit_x, hit_y;

  logic [9:0] step_pos, step_max, step_next;
  logic       step_dir, step_hit;
  logic       start;

  assign start = frame_start && !pause && (speed != 3'd0);
  assign busy  = (state != IDLE);

  // One shared stepper: x axis in CALC_X, y axis in CALC_Y.
  always_comb begin
    step_pos = sprite_x;
    step_dir = dir_x;
    step_max = X_MAX;
    if (state == CALC_Y) begin
      step_pos = sprite_y;
      step_dir = dir_y;
      step_max = Y_MAX;
    end
  end

  dvd_axis_step u_axis_step (
    .pos   (step_pos),
    .dir   (step_dir),
    .speed (speed_q),
    .max   (step_max),
    .next  (step_next),
    .hit   (step_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: fixed three-cycle walk once a frame is accepted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC_X;
      CALC_X:  next_state = CALC_Y;
      CALC_Y:  next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: speed captured at accept so a mid-frame change cannot split the axes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed_q   <= 3'd0;
      nx        <= '0;
      ny        <= '0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      sprite_x  <= X_INIT;
      sprite_y  <= Y_INIT;
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      color_idx <= 3'd1;
      bounce    <= 1'b0;
      corner    <= 1'b0;
    end else begin
      bounce <= 1'b0;
      corner <= 1'b0;
      case (state)
        IDLE: begin
          if (start) speed_q <= speed;
        end
        CALC_X: begin
          nx    <= step_next;
          hit_x <= step_hit;
        end
        CALC_Y: begin
          ny    <= step_next;
          hit_y <= step_hit;
        end
        COMMIT: begin
          sprite_x <= nx;
          sprite_y <= ny;
          if (hit_x) dir_x <= ~dir_x;
          if (hit_y) dir_y <= ~dir_y;
          bounce <= hit_x | hit_y;
          corner <= hit_x & hit_y;
          // A corner hit still advances the palette by one step only.
          if (hit_x | hit_y) color_idx <= next_color(color_idx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dvd_bounce_controller.sv
module tb_dvd_bounce_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fs;
  logic [2:0] pse;
  logic [2:0] spd [3];
  logic [9:0] sx [3];
  logic [9:0] sy [3];
  logic [2:0] col [3];
  logic [2:0] dxv, dyv, bnc, crn, bsy;

  int n_tests = 0;
  int n_failed = 0;

  always #5 clk = ~clk;

  // Instance 0: (200,200), instance 1: (508,200), instance 2: (510,2).
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dvd_bounce_controller #(
      .INIT_X (g == 0 ? 200 : (g == 1 ? 508 : 510)),
      .INIT_Y (g == 2 ? 2 : 200)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (fs[g]),
      .pause       (pse[g]),
      .speed       (spd[g]),
      .sprite_x    (sx[g]),
      .sprite_y    (sy[g]),
      .dir_x       (dxv[g]),
      .dir_y       (dyv[g]),
      .color_idx   (col[g]),
      .bounce      (bnc[g]),
      .corner      (crn[g]),
      .busy        (bsy[g])
    );
  end

  typedef struct {
    int         id;
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    logic [2:0] c;
    logic       b;
    logic       k;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int id, input int x, input int y, input bit dx, input bit dy,
                          input int c, input bit b, input bit k);
    exp_t e;
    e.id = id; e.x = 10'(x); e.y = 10'(y); e.dx = dx; e.dy = dy;
    e.c = 3'(c); e.b = b; e.k = k;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: a commit is busy falling while reset is released; pops and compares.
  logic [2:0] prev_busy = 3'b000;
  always @(negedge clk) begin
    logic cm;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cm = (prev_busy[i] === 1'b1) && (bsy[i] === 1'b0) && (rst_n === 1'b1);
      if (cm) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_failed++;
          $display("FAIL unexpected_commit inst%0d: got x=%0d y=%0d, expected no commit", i, sx[i], sy[i]);
        end else begin
          e = sb.pop_front();
          if (e.id != i || sx[i] !== e.x || sy[i] !== e.y || dxv[i] !== e.dx || dyv[i] !== e.dy ||
              col[i] !== e.c || bnc[i] !== e.b || crn[i] !== e.k) begin
            n_failed++;
            $display("FAIL commit inst%0d: got x=%0d y=%0d dx=%0b dy=%0b c=%0d b=%0b k=%0b, expected inst%0d x=%0d y=%0d dx=%0b dy=%0b c=%0d b=%0b k=%0b",
                     i, sx[i], sy[i], dxv[i], dyv[i], col[i], bnc[i], crn[i],
                     e.id, e.x, e.y, e.dx, e.dy, e.c, e.b, e.k);
          end
        end
      end else if (bnc[i] === 1'b1 || crn[i] === 1'b1) begin
        n_tests++;
        n_failed++;
        $display("FAIL stray_pulse inst%0d: got bounce=%0b corner=%0b outside commit, expected 0", i, bnc[i], crn[i]);
      end
    end
    prev_busy <= bsy;
  end

  // Issue one accepted frame; optionally re-pulse frame_start while in CALC_Y.
  task automatic do_frame(input int id, input bit mid_pulse, input string name);
    int cnt;
    int guard;
    @(posedge clk); #1;
    fs[id] = 1'b1;
    @(posedge clk); #1;
    fs[id] = 1'b0;
    cnt = 0;
    guard = 0;
    while (bsy[id] && guard < 20) begin
      cnt++;
      @(posedge clk); #1;
      fs[id] = mid_pulse && (cnt == 1);
      guard++;
    end
    fs[id] = 1'b0;
    chk({name, "_busy_cycles"}, cnt, 3);
  endtask

  int mx, my, mdx, mdy, mc, nb, frames, nxv, nyv;
  bit hx, hy;

  initial begin
    rst_n = 1'b0;
    fs = 3'b000;
    pse = 3'b000;
    for (int i = 0; i < 3; i++) spd[i] = 3'd0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_x0", sx[0], 200);
    chk("rst_y0", sy[0], 200);
    chk("rst_dx0", dxv[0], 1);
    chk("rst_dy0", dyv[0], 0);
    chk("rst_col0", col[0], 1);
    chk("rst_pulses", {bnc, crn}, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_x1", sx[1], 508);
    chk("rst_xy2", {sx[2], sy[2]}, {10'd510, 10'd2});

    // 2. speed 1, free move
    spd[0] = 3'd1;
    push_exp(0, 201, 199, 1, 0, 1, 0, 0);
    do_frame(0, 0, "t2");

    // 3. right edge clamp at 512
    spd[1] = 3'd4;
    push_exp(1, 512, 196, 0, 0, 2, 1, 0);
    do_frame(1, 0, "t3a");
    push_exp(1, 508, 192, 0, 0, 2, 0, 0);
    do_frame(1, 0, "t3b");

    // 4. corner: both axes reflect, colour advances once
    spd[2] = 3'd2;
    push_exp(2, 512, 0, 0, 1, 2, 1, 1);
    do_frame(2, 0, "t4a");
    push_exp(2, 510, 2, 0, 1, 2, 0, 0);
    do_frame(2, 0, "t4b");

    // 5. paused frame, then a frame re-pulsed during CALC_Y
    pse[0] = 1'b1;
    @(posedge clk); #1;
    fs[0] = 1'b1;
    @(posedge clk); #1;
    fs[0] = 1'b0;
    chk("t5_pause_busy", bsy[0], 0);
    pse[0] = 1'b0;
    spd[0] = 3'd0;
    @(posedge clk); #1;
    fs[0] = 1'b1;
    @(posedge clk); #1;
    fs[0] = 1'b0;
    chk("t5_speed0_busy", bsy[0], 0);
    chk("t5_hold_x", sx[0], 201);
    spd[0] = 3'd1;
    push_exp(0, 202, 198, 1, 0, 1, 0, 0);
    do_frame(0, 1, "t5");
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_requeue_busy", bsy[0], 0);

    // 6. run speed 7 until seven bounces; colour must wrap back to 1
    spd[0] = 3'd7;
    mx = 202; my = 198; mdx = 1; mdy = 0; mc = 1; nb = 0; frames = 0;
    while (nb < 7 && frames < 400) begin
      hx = 0; hy = 0;
      nxv = (mdx == 1) ? mx + 7 : mx - 7;
      if (mdx == 1 && nxv >= 512) begin nxv = 512; hx = 1; end
      if (mdx == 0 && nxv <= 0) begin nxv = 0; hx = 1; end
      nyv = (mdy == 1) ? my + 7 : my - 7;
      if (mdy == 1 && nyv >= 352) begin nyv = 352; hy = 1; end
      if (mdy == 0 && nyv <= 0) begin nyv = 0; hy = 1; end
      if (hx) mdx = 1 - mdx;
      if (hy) mdy = 1 - mdy;
      if (hx || hy) begin
        nb++;
        mc = (mc == 7) ? 1 : mc + 1;
      end
      mx = nxv; my = nyv;
      push_exp(0, mx, my, mdx[0], mdy[0], mc, hx || hy, hx && hy);
      do_frame(0, 0, "t6");
      frames++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t6_color_wrapped", col[0], 1);

    // reset asserted while in CALC_Y
    @(posedge clk); #1;
    fs[0] = 1'b1;
    @(posedge clk); #1;
    fs[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_busy", bsy[0], 0);
    chk("t6_rst_x", sx[0], 200);
    chk("t6_rst_y", sy[0], 200);
    chk("t6_rst_dir", {dxv[0], dyv[0]}, 2'b10);
    chk("t6_rst_color", col[0], 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
